// File: rtl/params_noc.sv
// Shared NoC types: coordinate width, flit labels, flit layout and port ids.
package params_noc;
  localparam int COORD_W   = 3;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  // Destination coordinates are only meaningful in head flits.
  typedef struct packed {
    logic [COORD_W-1:0]   x_dest;
    logic [COORD_W-1:0]   y_dest;
    logic [PAYLOAD_W-1:0] payload;
  } flit_data_t;

  typedef struct packed {
    flit_label_t flit_Label;
    flit_data_t  data;
  } flit_Data_noVC;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;
endpackage

// File: rtl/input_route_stage.sv
// Input-port route stage: XY-routes head flits, holds the allocator request
// for the whole packet and passes flits through while on/off credit allows.
module input_route_stage
  import params_noc::*;
#(
  parameter int X_CUR = 0,
  parameter int Y_CUR = 0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  flit_Data_noVC        buf_data_i,
  input  logic                 buf_empty_i,
  output logic                 buf_read_o,
  output logic                 req_valid_o,
  output logic [2:0]           out_port_o,
  input  logic                 grant_i,
  input  logic                 on_off_i,
  output flit_Data_noVC        flit_o,
  output logic                 flit_valid_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [CNT_W-1:0]     fwd_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

  localparam logic [COORD_W-1:0] XC = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y_CUR);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  state_t           state_q, state_d;
  port_t            port_q, port_d;
  logic [CNT_W-1:0] drop_cnt_q, fwd_cnt_q;
  logic             pop, fwd, drop;
  logic             is_head, is_tail;

  // XY routing: resolve X first, then Y, else deliver locally.
  function automatic port_t xy_route(input flit_data_t d);
    port_t r;
    if (d.x_dest > XC)      r = EAST;
    else if (d.x_dest < XC) r = WEST;
    else if (d.y_dest > YC) r = SOUTH;
    else if (d.y_dest < YC) r = NORTH;
    else                    r = LOCAL;
    return r;
  endfunction

  assign is_head = (buf_data_i.flit_Label == HEAD) || (buf_data_i.flit_Label == HEADTAIL);
  assign is_tail = (buf_data_i.flit_Label == TAIL) || (buf_data_i.flit_Label == HEADTAIL);

  // Next-state, route capture and per-cycle pop/forward/drop decisions.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    pop     = 1'b0;
    fwd     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!buf_empty_i) begin
          if (is_head) begin
            // Route is latched now; the head stays in the buffer until ACTIVE.
            port_d  = xy_route(buf_data_i.data);
            state_d = S_REQ;
          end else begin
            // Body/tail with no owning head: discard it.
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (grant_i) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // A stray HEAD label here is simply forwarded as payload.
        if (!buf_empty_i && on_off_i) begin
          pop = 1'b1;
          fwd = 1'b1;
          if (is_tail) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched route and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      port_q     <= LOCAL;
      drop_cnt_q <= '0;
      fwd_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      if (drop && (drop_cnt_q != CNT_MAX)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (fwd && (fwd_cnt_q != CNT_MAX))   fwd_cnt_q  <= fwd_cnt_q + CNT_W'(1);
    end
  end

  // Combinational strobes are masked by reset so they read 0 the instant it asserts.
  assign buf_read_o   = pop & rst_n;
  assign flit_valid_o = fwd & rst_n;
  assign flit_o       = flit_valid_o ? buf_data_i : '0;
  assign req_valid_o  = (state_q != S_IDLE);
  assign out_port_o   = port_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign fwd_cnt_o    = fwd_cnt_q;

endmodule

// File: tb/tb_input_route_stage.sv
// Bench for input_route_stage at router (1,1): directed timing scenarios plus a
// randomized packet stream scored against an in-order flit/route scoreboard.
module tb_input_route_stage;
  import params_noc::*;

  localparam int CNT_W = 8;
  localparam int CMAXI = (1 << CNT_W) - 1;
  localparam int XR = 1;
  localparam int YR = 1;

  logic               clk, rst_n;
  flit_Data_noVC      buf_data_i, flit_o;
  logic               buf_empty_i, buf_read_o, req_valid_o, grant_i, on_off_i, flit_valid_o;
  logic [2:0]         out_port_o;
  logic [CNT_W-1:0]   drop_cnt_o, fwd_cnt_o;

  input_route_stage #(.X_CUR(XR), .Y_CUR(YR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .buf_data_i(buf_data_i), .buf_empty_i(buf_empty_i),
    .buf_read_o(buf_read_o), .req_valid_o(req_valid_o), .out_port_o(out_port_o),
    .grant_i(grant_i), .on_off_i(on_off_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
    .drop_cnt_o(drop_cnt_o), .fwd_cnt_o(fwd_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: flit queue plus orphan tag per entry.
  flit_Data_noVC bq[$];
  bit            bo[$];
  int n_chk, n_pass;
  int exp_fwd, exp_drop;

  // Outputs captured mid-cycle by cycle().
  logic o_read, o_fv, o_req;
  logic [2:0] o_port;
  flit_Data_noVC o_flit, popped;
  logic [CNT_W-1:0] o_fwd, o_drop;
  bit pop_orph, c_empty, c_onoff;

  function automatic flit_Data_noVC mk(flit_label_t l, int x, int y);
    flit_Data_noVC f;
    f.flit_Label   = l;
    f.data.x_dest  = COORD_W'(x);
    f.data.y_dest  = COORD_W'(y);
    f.data.payload = PAYLOAD_W'($urandom);
    return f;
  endfunction

  function automatic logic [2:0] ref_port(int x, int y);
    if (x > XR) return 3'd4;
    if (x < XR) return 3'd3;
    if (y > YR) return 3'd2;
    if (y < YR) return 3'd1;
    return 3'd0;
  endfunction

  function automatic int sat(int v);
    return (v > CMAXI) ? CMAXI : v;
  endfunction

  task automatic push_pkt(int len, int x, int y);
    if (len == 1) begin bq.push_back(mk(HEADTAIL, x, y)); bo.push_back(1'b0); end
    else begin
      bq.push_back(mk(HEAD, x, y)); bo.push_back(1'b0);
      for (int i = 1; i < len - 1; i++) begin bq.push_back(mk(BODY, x, y)); bo.push_back(1'b0); end
      bq.push_back(mk(TAIL, x, y)); bo.push_back(1'b0);
    end
  endtask

  task automatic push_orphan(flit_label_t l);
    bq.push_back(mk(l, $urandom_range(0, 7), $urandom_range(0, 7)));
    bo.push_back(1'b1);
  endtask

  // One clock: present buffer head (unless hidden), sample at negedge, pop on read.
  task automatic cycle(input bit hide, input bit onoff, input bit gnt);
    if (bq.size() > 0 && !hide) begin buf_empty_i = 1'b0; buf_data_i = bq[0]; end
    else begin buf_empty_i = 1'b1; buf_data_i = '0; end
    on_off_i = onoff; grant_i = gnt;
    c_empty = buf_empty_i; c_onoff = onoff;
    @(negedge clk);
    o_read = buf_read_o; o_fv = flit_valid_o; o_req = req_valid_o; o_port = out_port_o;
    o_flit = flit_o; o_fwd = fwd_cnt_o; o_drop = drop_cnt_o;
    pop_orph = 1'b0; popped = '0;
    if (buf_read_o && bq.size() > 0) begin popped = bq.pop_front(); pop_orph = bo.pop_front(); end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; buf_empty_i = 1'b1; buf_data_i = '0; on_off_i = 1'b0; grant_i = 1'b0;
    bq.delete(); bo.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_fwd = 0; exp_drop = 0;
  endtask

  task automatic test_reset();
    bq.delete(); bo.delete();
    buf_empty_i = 1'b0; buf_data_i = mk(BODY, 0, 0); on_off_i = 1'b1; grant_i = 1'b1;
    rst_n = 1'b0; #1;
    n_chk++; if ({buf_read_o, flit_valid_o, req_valid_o} !== 3'b000) $display("FAIL reset_strobes got=%b want=000", {buf_read_o, flit_valid_o, req_valid_o}); else n_pass++;
    n_chk++; if (out_port_o !== 3'd0) $display("FAIL reset_port got=%0d want=0", out_port_o); else n_pass++;
    n_chk++; if (flit_o !== '0) $display("FAIL reset_flit got=%h want=0", flit_o); else n_pass++;
    n_chk++; if ({fwd_cnt_o, drop_cnt_o} !== '0) $display("FAIL reset_cnt got=%0d/%0d want=0/0", fwd_cnt_o, drop_cnt_o); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; buf_empty_i = 1'b1;
    @(posedge clk); #1;
    exp_fwd = 0; exp_drop = 0;
  endtask

  task automatic test_headtail();
    flit_Data_noVC f;
    push_pkt(1, 3, 1); f = bq[0];
    cycle(0, 1, 1);
    n_chk++; if ({o_req, o_fv, o_read} !== 3'b000) $display("FAIL ht_N got=%b want=000", {o_req, o_fv, o_read}); else n_pass++;
    cycle(0, 1, 1);
    n_chk++; if ({o_req, o_fv, o_read} !== 3'b100) $display("FAIL ht_N1 got=%b want=100", {o_req, o_fv, o_read}); else n_pass++;
    n_chk++; if (o_port !== ref_port(3, 1)) $display("FAIL ht_port got=%0d want=%0d", o_port, ref_port(3, 1)); else n_pass++;
    cycle(0, 1, 1);
    n_chk++; if ({o_fv, o_read} !== 2'b11 || o_flit !== f) $display("FAIL ht_N2 got=%b/%h want=11/%h", {o_fv, o_read}, o_flit, f); else n_pass++;
    exp_fwd++;
    cycle(0, 1, 1);
    n_chk++; if ({o_req, o_fv} !== 2'b00) $display("FAIL ht_N3 got=%b want=00", {o_req, o_fv}); else n_pass++;
    n_chk++; if (int'(o_fwd) !== sat(exp_fwd)) $display("FAIL ht_fwd got=%0d want=%0d", o_fwd, sat(exp_fwd)); else n_pass++;
  endtask

  task automatic test_wait_grant();
    flit_Data_noVC ex[$];
    push_pkt(4, 1, 0); ex = bq;
    cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0);
      n_chk++; if ({o_req, o_port, o_fv} !== {1'b1, ref_port(1, 0), 1'b0}) $display("FAIL wg_req%0d got=%b want=%b", i, {o_req, o_port, o_fv}, {1'b1, ref_port(1, 0), 1'b0}); else n_pass++;
    end
    cycle(0, 1, 1);
    n_chk++; if ({o_req, o_fv} !== 2'b10) $display("FAIL wg_grant got=%b want=10", {o_req, o_fv}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1);
      n_chk++; if (o_fv !== 1'b1 || o_flit !== ex[i]) $display("FAIL wg_xfer%0d got=%b/%h want=1/%h", i, o_fv, o_flit, ex[i]); else n_pass++;
    end
    exp_fwd += 4;
    cycle(0, 1, 1);
    n_chk++; if (o_req !== 1'b0) $display("FAIL wg_drop got=%b want=0", o_req); else n_pass++;
    n_chk++; if (int'(o_fwd) !== sat(exp_fwd)) $display("FAIL wg_fwd got=%0d want=%0d", o_fwd, sat(exp_fwd)); else n_pass++;
  endtask

  task automatic test_onoff_stall();
    flit_Data_noVC ex[$];
    push_pkt(5, 0, 1); ex = bq;
    cycle(0, 1, 1); cycle(0, 1, 1);
    cycle(0, 1, 1);
    n_chk++; if (o_fv !== 1'b1 || o_flit !== ex[0]) $display("FAIL st_head got=%b/%h want=1/%h", o_fv, o_flit, ex[0]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1);
      n_chk++; if ({o_read, o_fv, o_req, o_port} !== {3'b001, ref_port(0, 1)}) $display("FAIL st_off%0d got=%b want=%b", i, {o_read, o_fv, o_req, o_port}, {3'b001, ref_port(0, 1)}); else n_pass++;
    end
    cycle(1, 1, 1);
    n_chk++; if ({o_read, o_fv} !== 2'b00) $display("FAIL st_empty got=%b want=00", {o_read, o_fv}); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      cycle(0, 1, 1);
      n_chk++; if (o_fv !== 1'b1 || o_flit !== ex[i]) $display("FAIL st_xfer%0d got=%b/%h want=1/%h", i, o_fv, o_flit, ex[i]); else n_pass++;
    end
    exp_fwd += 5;
    cycle(0, 1, 1);
    n_chk++; if (int'(o_fwd) !== sat(exp_fwd) || bq.size() != 0) $display("FAIL st_count got=%0d left=%0d want=%0d left=0", o_fwd, bq.size(), sat(exp_fwd)); else n_pass++;
  endtask

  task automatic test_orphan();
    push_orphan(BODY); push_orphan(TAIL);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 1);
      n_chk++; if ({o_read, o_fv, o_req} !== 3'b100) $display("FAIL orph_pop%0d got=%b want=100", i, {o_read, o_fv, o_req}); else n_pass++;
    end
    exp_drop += 2;
    cycle(0, 1, 1);
    n_chk++; if (o_read !== 1'b0) $display("FAIL orph_empty got=%b want=0", o_read); else n_pass++;
    n_chk++; if (int'(o_drop) !== sat(exp_drop)) $display("FAIL orph_drop got=%0d want=%0d", o_drop, sat(exp_drop)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    flit_Data_noVC f;
    push_pkt(4, 2, 2);
    cycle(0, 1, 1); cycle(0, 1, 1); cycle(0, 1, 1);
    buf_empty_i = 1'b0; buf_data_i = bq[0]; on_off_i = 1'b1; grant_i = 1'b1; #1;
    n_chk++; if (flit_valid_o !== 1'b1) $display("FAIL rm_active got=%b want=1", flit_valid_o); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if ({buf_read_o, flit_valid_o, req_valid_o, out_port_o} !== 6'd0 || flit_o !== '0) $display("FAIL rm_outs got=%b/%h want=0/0", {buf_read_o, flit_valid_o, req_valid_o, out_port_o}, flit_o); else n_pass++;
    n_chk++; if ({fwd_cnt_o, drop_cnt_o} !== '0) $display("FAIL rm_cnt got=%0d/%0d want=0/0", fwd_cnt_o, drop_cnt_o); else n_pass++;
    @(posedge clk); @(negedge clk);
    bq.delete(); bo.delete(); buf_empty_i = 1'b1; exp_fwd = 0; exp_drop = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_pkt(1, 1, 2); f = bq[0];
    cycle(0, 1, 1);
    n_chk++; if (o_req !== 1'b0) $display("FAIL rm_N got=%b want=0", o_req); else n_pass++;
    cycle(0, 1, 1);
    n_chk++; if ({o_req, o_port} !== {1'b1, ref_port(1, 2)}) $display("FAIL rm_route got=%b want=%b", {o_req, o_port}, {1'b1, ref_port(1, 2)}); else n_pass++;
    cycle(0, 1, 1);
    n_chk++; if (o_fv !== 1'b1 || o_flit !== f) $display("FAIL rm_fwd got=%b/%h want=1/%h", o_fv, o_flit, f); else n_pass++;
    exp_fwd++;
    cycle(0, 1, 1);
    n_chk++; if (int'(o_fwd) !== sat(exp_fwd)) $display("FAIL rm_cnt_restart got=%0d want=%0d", o_fwd, sat(exp_fwd)); else n_pass++;
  endtask

  task automatic test_local_sat();
    int k;
    push_pkt(1, 1, 1);
    cycle(0, 1, 1); cycle(0, 1, 1);
    n_chk++; if ({o_req, o_port} !== {1'b1, ref_port(1, 1)}) $display("FAIL loc_port got=%b want=%b", {o_req, o_port}, {1'b1, ref_port(1, 1)}); else n_pass++;
    cycle(0, 1, 1);
    exp_fwd++;
    push_pkt(300, 0, 0);
    k = 0;
    while (bq.size() > 0 && k < 400) begin cycle(0, 1, 1); k++; end
    exp_fwd += 300;
    for (int i = 0; i < 300; i++) push_orphan((i % 2) ? TAIL : BODY);
    k = 0;
    while (bq.size() > 0 && k < 400) begin cycle(0, 1, 1); k++; end
    exp_drop += 300;
    cycle(0, 1, 1);
    n_chk++; if (bq.size() != 0) $display("FAIL sat_drain got=%0d left want=0", bq.size()); else n_pass++;
    n_chk++; if (int'(o_fwd) !== sat(exp_fwd)) $display("FAIL sat_fwd got=%0d want=%0d", o_fwd, sat(exp_fwd)); else n_pass++;
    n_chk++; if (int'(o_drop) !== sat(exp_drop)) $display("FAIL sat_drop got=%0d want=%0d", o_drop, sat(exp_drop)); else n_pass++;
  endtask

  task automatic test_random();
    flit_Data_noVC sb[$];
    logic [2:0]    pq[$];
    int gen_fwd, gen_drop, cyc, len, x, y;
    do_reset();
    gen_fwd = 0; gen_drop = 0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < $urandom_range(1, 2); j++) begin push_orphan($urandom_range(0, 1) ? TAIL : BODY); gen_drop++; end
      end
      len = $urandom_range(1, 6); x = $urandom_range(0, 7); y = $urandom_range(0, 7);
      pq.push_back(ref_port(x, y));
      push_pkt(len, x, y); gen_fwd += len;
    end
    for (int i = 0; i < bq.size(); i++) if (!bo[i]) sb.push_back(bq[i]);
    cyc = 0;
    while (bq.size() > 0 && cyc < 3000) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1));
      cyc++;
      if (o_read) begin
        n_chk++; if (c_empty) $display("FAIL rnd_read_empty got=1 want=0 cyc=%0d", cyc); else n_pass++;
      end
      if (o_req && pq.size() > 0) begin
        n_chk++; if (o_port !== pq[0]) $display("FAIL rnd_port got=%0d want=%0d cyc=%0d", o_port, pq[0], cyc); else n_pass++;
      end
      if (o_fv) begin
        n_chk++;
        if (sb.size() == 0 || pop_orph || !c_onoff || !o_req || o_flit !== sb[0] || popped !== sb[0])
          $display("FAIL rnd_fwd got=%h orph=%0d onoff=%0d want=%h cyc=%0d", o_flit, pop_orph, c_onoff, (sb.size() > 0) ? sb[0] : '0, cyc);
        else n_pass++;
        if (sb.size() > 0) begin
          if (sb[0].flit_Label == TAIL || sb[0].flit_Label == HEADTAIL) void'(pq.pop_front());
          void'(sb.pop_front());
        end
      end else if (o_read) begin
        n_chk++; if (!pop_orph || o_req) $display("FAIL rnd_drop got=orph%0d/req%0d want=orph1/req0 cyc=%0d", pop_orph, o_req, cyc); else n_pass++;
      end
    end
    cycle(1, 0, 0);
    n_chk++; if (bq.size() != 0 || sb.size() != 0) $display("FAIL rnd_drain got=%0d/%0d left want=0/0", bq.size(), sb.size()); else n_pass++;
    n_chk++; if (int'(o_fwd) !== sat(gen_fwd)) $display("FAIL rnd_fwd_cnt got=%0d want=%0d", o_fwd, sat(gen_fwd)); else n_pass++;
    n_chk++; if (int'(o_drop) !== sat(gen_drop)) $display("FAIL rnd_drop_cnt got=%0d want=%0d", o_drop, sat(gen_drop)); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; exp_fwd = 0; exp_drop = 0;
    rst_n = 1'b0; buf_empty_i = 1'b1; buf_data_i = '0; on_off_i = 1'b0; grant_i = 1'b0;
    test_reset();
    test_headtail();
    test_wait_grant();
    test_onoff_stall();
    test_orphan();
    test_reset_mid();
    test_local_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
